// File: rtl/md_sched_if.sv
// -----------------------------------------------------------------------------
// md_sched_if
//  Bundles every signal between the multiply/divide sequencer and its
//  neighbours: the EX-stage request, pipeline control, the multiplier and
//  divider unit ports, and the HI/LO write pair.
//  Modports:
//   slave  - the sequencer (md_sched) view
//   master - the surrounding pipeline / unit view
//  Signals:
//   req_valid, req_op[1:0], req_src1[31:0], req_src2[31:0]  EX request
//   ex_adv, annul                                           pipeline control in
//   stallreq, busy                                          pipeline control out
//   mul_signed, mul_ina, mul_inb / mul_result               multiplier
//   div_start, div_signed, div_opdata1/2, div_annul /
//   div_ready, div_result                                   divider
//   hi_we, lo_we, hi_wdata, lo_wdata, md_err                HI/LO write, error
// -----------------------------------------------------------------------------
interface md_sched_if;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [31:0] req_src1;
   logic [31:0] req_src2;
   logic        ex_adv;
   logic        annul;
   logic        stallreq;
   logic        busy;
   logic        mul_signed;
   logic [31:0] mul_ina;
   logic [31:0] mul_inb;
   logic [63:0] mul_result;
   logic        div_start;
   logic        div_signed;
   logic [31:0] div_opdata1;
   logic [31:0] div_opdata2;
   logic        div_annul;
   logic        div_ready;
   logic [63:0] div_result;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] hi_wdata;
   logic [31:0] lo_wdata;
   logic        md_err;

   modport slave (
      input  req_valid, req_op, req_src1, req_src2, ex_adv, annul,
      input  mul_result, div_ready, div_result,
      output stallreq, busy, mul_signed, mul_ina, mul_inb,
      output div_start, div_signed, div_opdata1, div_opdata2, div_annul,
      output hi_we, lo_we, hi_wdata, lo_wdata, md_err
   );

   modport master (
      output req_valid, req_op, req_src1, req_src2, ex_adv, annul,
      output mul_result, div_ready, div_result,
      input  stallreq, busy, mul_signed, mul_ina, mul_inb,
      input  div_start, div_signed, div_opdata1, div_opdata2, div_annul,
      input  hi_we, lo_we, hi_wdata, lo_wdata, md_err
   );
endinterface

// File: rtl/md_sched.sv
// -----------------------------------------------------------------------------
// md_sched
//  EX-stage sequencer for the shared multi-cycle multiplier and iterative
//  divider. Accepts one mult/multu/div/divu request, launches the matching
//  unit, stalls the pipeline until the 64-bit result is captured, then drives
//  the HI/LO write pair until EX advances.
//  Ports:
//   clk     clock
//   resetn  asynchronous active-low reset
//   md      md_sched_if.slave (request, pipeline control, mul/div unit ports,
//           HI/LO write pair, md_err)
//  Parameters:
//   MUL_LAT      multiplier cycles after operands are registered (>=1)
//   DIV_TIMEOUT  max cycles waiting for div_ready before aborting
//   CNT_W        counter width, must hold max(MUL_LAT, DIV_TIMEOUT)
//  Build option:
//   MD_ZERO_FAST_EN  when defined, requests with a zero operand (either mul
//                    operand, or the divisor) skip the unit and complete in
//                    one cycle.
// -----------------------------------------------------------------------------
module md_sched #(
   parameter int MUL_LAT     = 2,
   parameter int DIV_TIMEOUT = 40,
   parameter int CNT_W       = 6
) (
   input  logic       clk,
   input  logic       resetn,
   md_sched_if.slave  md
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_TIMEOUT - 1);

   logic [1:0]       state;
   logic [1:0]       op_q;
   logic [31:0]      src1_q;
   logic [31:0]      src2_q;
   logic [CNT_W-1:0] cnt;
   logic [63:0]      res64;

   logic             accept;
   logic             in_mul;
   logic             in_div;
   logic             in_done;
   logic             div_timeout;
   logic [1:0]       launch_state;

`ifdef MD_ZERO_FAST_EN
   logic             zero_hit;
   logic [63:0]      zero_res;
`endif

   assign in_mul  = (state == S_MUL);
   assign in_div  = (state == S_DIV);
   assign in_done = (state == S_DONE);
   assign accept  = (state == S_IDLE) & md.req_valid & ~md.annul;

   // Timeout fires only if neither a flush nor a result arrived this cycle;
   // annul wins over both, and a result on the last cycle still counts.
   assign div_timeout = in_div & ~md.annul & ~md.div_ready & (cnt == DIV_LAST);

   // Where an accepted request goes next.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // through the block can leave it unassigned and infer a latch.
      launch_state = md.req_op[1] ? S_DIV : S_MUL;
`ifdef MD_ZERO_FAST_EN
      zero_hit = 1'b0;
      zero_res = '0;
      if (md.req_op[1]) begin
         zero_hit = (md.req_src2 == 32'd0);
         zero_res = {md.req_src1, 32'hFFFF_FFFF};
      end else begin
         zero_hit = (md.req_src1 == 32'd0) | (md.req_src2 == 32'd0);
      end
      if (zero_hit) launch_state = S_DONE;
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values, independent of statement order.
         state  <= S_IDLE;
         op_q   <= '0;
         src1_q <= '0;
         src2_q <= '0;
         cnt    <= '0;
         res64  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q   <= md.req_op;
                  src1_q <= md.req_src1;
                  src2_q <= md.req_src2;
                  cnt    <= '0;
`ifdef MD_ZERO_FAST_EN
                  // Only consumed when launch_state is DONE; a unit result
                  // overwrites it otherwise.
                  res64  <= zero_res;
`endif
                  state  <= launch_state;
               end
            end
            S_MUL: begin
               if (md.annul) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == MUL_LAST) begin
                     res64 <= md.mul_result;
                     state <= S_DONE;
                  end
               end
            end
            S_DIV: begin
               if (md.annul) begin
                  state <= S_IDLE;
               end else if (md.div_ready) begin
                  res64 <= md.div_result;
                  state <= S_DONE;
               end else if (div_timeout) begin
                  res64 <= '0;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin // S_DONE
               // Leaving on ex_adv means the request still held this cycle
               // has already been retired, so IDLE never relaunches it.
               if (md.annul | md.ex_adv) state <= S_IDLE;
            end
         endcase
      end
   end

   // Pipeline control. stallreq is forced low during reset because the IDLE
   // term depends on req_valid, which reset does not clear.
   assign md.stallreq = resetn & (accept | in_mul | in_div);
   assign md.busy     = (state != S_IDLE);

   // Multiplier operands come straight from the latches, so they stay stable
   // from accept through DONE.
   assign md.mul_signed = md.busy & ~op_q[1] & ~op_q[0];
   assign md.mul_ina    = src1_q;
   assign md.mul_inb    = src2_q;

   assign md.div_start   = in_div & ~md.div_ready & ~md.annul & ~div_timeout;
   assign md.div_signed  = in_div & ~op_q[0];
   assign md.div_opdata1 = src1_q;
   assign md.div_opdata2 = src2_q;
   assign md.div_annul   = in_div & (md.annul | div_timeout);
   assign md.md_err      = div_timeout;

   // The write repeats every DONE cycle; HI/LO writes are idempotent.
   assign md.hi_we    = in_done & ~md.annul;
   assign md.lo_we    = in_done & ~md.annul;
   assign md.hi_wdata = in_done ? res64[63:32] : 32'd0;
   assign md.lo_wdata = in_done ? res64[31:0]  : 32'd0;

endmodule
